// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests into the stall bus,
// redirects the PC on exception/eret, and tracks stall statistics and a watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [15:0] WDOG_LIMIT = 16'd1024,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  logic             excp_is_eret,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             wdog_timeout
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [15:0]      run_len_q, run_len_d;
  logic [15:0]      run_base;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             wdog_q, wdog_d;
  logic [5:0]       stall_req;

  // Deepest requesting stage wins; it and everything upstream freeze.
  always_comb begin
    stall_req = 6'b000000;
    priority case (1'b1)
      stallreq_mem: stall_req = 6'b011111;
      stallreq_ex:  stall_req = 6'b001111;
      stallreq_id:  stall_req = 6'b000111;
      stallreq_if:  stall_req = 6'b000011;
      default:      stall_req = 6'b000000;
    endcase
  end

  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0000_0000;
    if (excp_valid) begin
      flush  = 1'b1;
      new_pc = excp_is_eret ? cp0_epc : EXC_VECTOR;
    end else begin
      stall = stall_req;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (flush) begin
      state_d = ST_FLUSH;
    end else if (stall != 6'b000000) begin
      state_d = ST_STALL;
    end
  end

  // A stall run only continues if the previous cycle was also a stall;
  // the 2'b11 encoding therefore behaves like RUN.
  always_comb begin
    run_base       = (state_q == ST_STALL) ? run_len_q : 16'd0;
    run_len_d      = 16'd0;
    wdog_d         = wdog_q;
    stall_cycles_d = stall_cycles_q;
    if (state_d == ST_STALL) begin
      run_len_d = (run_base == 16'hFFFF) ? run_base : run_base + 16'd1;
      if (run_base >= WDOG_LIMIT - 16'd1) begin
        wdog_d = 1'b1;
      end
      if (!(&stall_cycles_q)) begin
        stall_cycles_d = stall_cycles_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      run_len_q      <= 16'd0;
      stall_cycles_q <= '0;
      wdog_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_len_q      <= run_len_d;
      stall_cycles_q <= stall_cycles_d;
      wdog_q         <= wdog_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign wdog_timeout = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic,
// all checked against a behavioural model of the stall/flush rules.
module tb_pipe_ctrl;

  localparam int LIM = 8;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic          excp_valid, excp_is_eret;
  logic [31:0]   cp0_epc;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic [CW-1:0] stall_cycles;
  logic          wdog_timeout;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR(32'h0000_0020),
    .WDOG_LIMIT(16'd8),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_if(stallreq_if),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid),
    .excp_is_eret(excp_is_eret),
    .cp0_epc(cp0_epc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .stall_cycles(stall_cycles),
    .wdog_timeout(wdog_timeout)
  );

  int vectors = 0;
  int miscompares = 0;
  int m_cnt = 0;
  int m_run = 0;
  bit m_wdog = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stages numbered IF=1..MEM=4: a request at stage k freezes pc plus k registers.
  function automatic logic [5:0] exp_stall(bit i, bit d, bit e, bit m, bit ev);
    int nbits;
    if (ev) return 6'd0;
    nbits = m ? 5 : e ? 4 : d ? 3 : i ? 2 : 0;
    return 6'((1 << nbits) - 1);
  endfunction

  task automatic step(input bit r, input bit i, input bit d, input bit e,
                      input bit m, input bit ev, input bit er,
                      input logic [31:0] epc, input string tag);
    logic [5:0]  es;
    logic [31:0] epc_exp;
    rst = r;
    stallreq_if = i;
    stallreq_id = d;
    stallreq_ex = e;
    stallreq_mem = m;
    excp_valid = ev;
    excp_is_eret = er;
    cp0_epc = epc;
    #1;
    es = exp_stall(i, d, e, m, ev);
    epc_exp = !ev ? 32'h0 : (er ? epc : 32'h0000_0020);
    chk({tag, "/stall"}, 32'(stall), 32'(es));
    chk({tag, "/flush"}, 32'(flush), 32'(ev));
    chk({tag, "/new_pc"}, new_pc, epc_exp);
    @(posedge clk);
    if (r) begin
      m_cnt = 0;
      m_run = 0;
      m_wdog = 1'b0;
    end else if (es != 6'd0) begin
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_run++;
      if (m_run >= LIM) m_wdog = 1'b1;
    end else begin
      m_run = 0;
    end
    #1;
    chk({tag, "/stall_cycles"}, 32'(stall_cycles), 32'(m_cnt));
    chk({tag, "/wdog"}, 32'(wdog_timeout), 32'(m_wdog));
  endtask

  initial begin
    // reset and idle
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, "rst0");
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, "rst1");
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 0, 0, 32'h0, "idle");
    chk("idle_cnt_const", 32'(stall_cycles), 32'd0);

    // id+ex together
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 0, 0, 0, 32'h0, "id_ex");
      chk("id_ex_bus_const", 32'(stall), 32'h0000_000F);
    end
    chk("id_ex_cnt_const", 32'(stall_cycles), 32'd3);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, "after_id_ex");

    // exception during mem stall, eret, eret qualifier without valid
    step(0, 0, 0, 0, 1, 1, 0, 32'hDEAD_BEEF, "mem_excp");
    chk("mem_excp_cnt_const", 32'(stall_cycles), 32'd3);
    step(0, 1, 0, 0, 0, 1, 1, 32'h0000_1234, "eret");
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_1234, "eret_no_valid");
    step(0, 1, 1, 1, 1, 0, 0, 32'h0, "all_req");

    // watchdog: 8 consecutive stalls trips, sticky
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, "wd_rst");
    for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0, 0, 0, 32'h0, "wd_hold");
    chk("wd_after7_const", 32'(wdog_timeout), 32'd0);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0, "wd_8th");
    chk("wd_after8_const", 32'(wdog_timeout), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, "wd_drop");
    chk("wd_sticky_const", 32'(wdog_timeout), 32'd1);

    // 7 + run + 7 never trips; flush also breaks a run
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, "wd2_rst");
    for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0, 0, 0, 32'h0, "wd2_a");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, "wd2_gap");
    for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0, 0, 0, 32'h0, "wd2_b");
    step(0, 0, 0, 0, 1, 1, 0, 32'h0, "wd2_flush");
    for (int k = 0; k < 7; k++) step(0, 0, 1, 0, 0, 0, 0, 32'h0, "wd2_c");
    chk("wd2_quiet_const", 32'(wdog_timeout), 32'd0);

    // counter saturation and reset mid-stall
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, "sat_rst");
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1, 0, 0, 32'h0, "sat");
    chk("sat_cnt_const", 32'(stall_cycles), 32'h0000_000F);
    step(1, 0, 0, 0, 1, 0, 0, 32'h0, "rst_mid");
    chk("rst_mid_cnt_const", 32'(stall_cycles), 32'd0);
    chk("rst_mid_wdog_const", 32'(wdog_timeout), 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0, "post_rst");

    // random traffic, stall-heavy so watchdog runs occur
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
           $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
